// File: rtl/mul_div_issue_arbiter_pkg.sv
// rtl/mul_div_issue_arbiter_pkg.sv - shared widths and request types for the mul/div issue arbiter
// Default widths follow the issue-to-execute bus; the payload carries an instruction pair.
package mul_div_issue_arbiter_pkg;

  localparam int ROB_IDX_W = 4;
  localparam int CNT_W     = 16;

  typedef logic [79:0] issue_to_execute_bus_t;
  localparam int PAYLOAD_W = $bits(issue_to_execute_bus_t) * 2;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic                 valid;
    rob_idx_t             rob;
    logic [PAYLOAD_W-1:0] payload;
  } md_req_t;

endpackage

// File: rtl/mul_div_issue_arbiter_rob_age_cmp.sv
// rtl/mul_div_issue_arbiter_rob_age_cmp.sv - ROB age comparator
// Ages are distances from the ROB head modulo the index range; ties favour side a.
module mul_div_issue_arbiter_rob_age_cmp #(
  parameter int ROB_IDX_W = mul_div_issue_arbiter_pkg::ROB_IDX_W
) (
  input  logic [ROB_IDX_W-1:0] rob_a,
  input  logic [ROB_IDX_W-1:0] rob_b,
  input  logic [ROB_IDX_W-1:0] rob_head,
  output logic                 older_is_b
);

  logic [ROB_IDX_W-1:0] age_a;
  logic [ROB_IDX_W-1:0] age_b;

  always_comb begin
    age_a      = rob_a - rob_head;
    age_b      = rob_b - rob_head;
    older_is_b = (age_b < age_a);
  end

endmodule

// File: rtl/mul_div_issue_arbiter.sv
// rtl/mul_div_issue_arbiter.sv - oldest-first arbiter feeding the shared mul/div unit
// One-entry output register; grants only when that register can load.
module mul_div_issue_arbiter
  import mul_div_issue_arbiter_pkg::*;
#(
  parameter int ROB_IDX_W = mul_div_issue_arbiter_pkg::ROB_IDX_W,
  parameter int PAYLOAD_W = mul_div_issue_arbiter_pkg::PAYLOAD_W,
  parameter int CNT_W     = mul_div_issue_arbiter_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ROB_IDX_W-1:0] rob_head,
  input  logic                 req0_valid,
  input  logic [ROB_IDX_W-1:0] req0_rob,
  input  logic [PAYLOAD_W-1:0] req0_payload,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ROB_IDX_W-1:0] req1_rob,
  input  logic [PAYLOAD_W-1:0] req1_payload,
  output logic                 req1_ready,
  input  logic                 md_allowin,
  output logic                 md_valid,
  output logic [PAYLOAD_W-1:0] md_payload,
  output logic                 md_src,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic older_is_1;
  logic load;
  logic grant0;
  logic grant1;

  mul_div_issue_arbiter_rob_age_cmp #(.ROB_IDX_W(ROB_IDX_W)) u_age_cmp (
    .rob_a      (req0_rob),
    .rob_b      (req1_rob),
    .rob_head   (rob_head),
    .older_is_b (older_is_1)
  );

  always_comb begin
    load   = !md_valid || md_allowin;
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (load && !flush && !reset) begin
      grant0 = req0_valid && (!req1_valid || !older_is_1);
      grant1 = req1_valid && (!req0_valid ||  older_is_1);
    end
    req0_ready = grant0;
    req1_ready = grant1;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      md_valid   <= 1'b0;
      md_payload <= '0;
      md_src     <= 1'b0;
    end else if (load) begin
      md_valid   <= grant0 || grant1;
      md_payload <= grant1 ? req1_payload : (grant0 ? req0_payload : '0);
      md_src     <= grant1;
    end
  end

  // Performance counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (req0_valid && req1_valid && !flush && (conflict_cnt != {CNT_W{1'b1}})) begin
      conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_div_issue_arbiter.sv
// tb/tb_mul_div_issue_arbiter.sv - directed self-checking bench for mul_div_issue_arbiter
// A second instance with a 4-bit counter exercises saturation on the same stimulus.
module tb_mul_div_issue_arbiter;

  localparam int RW = 4;
  localparam int PW = 160;

  localparam logic [PW-1:0] P0 = {5{32'hA5A5_0001}};
  localparam logic [PW-1:0] P1 = {5{32'h1111_2222}};
  localparam logic [PW-1:0] P2 = {5{32'h3333_4444}};
  localparam logic [PW-1:0] P3 = {5{32'h5555_6666}};
  localparam logic [PW-1:0] P4 = {5{32'h7777_8888}};
  localparam logic [PW-1:0] P5 = {5{32'h9999_AAAA}};
  localparam logic [PW-1:0] P6 = {5{32'hBBBB_CCCC}};

  logic          clk = 1'b0;
  logic          reset, flush, md_allowin;
  logic [RW-1:0] rob_head;
  logic          req0_valid, req1_valid;
  logic [RW-1:0] req0_rob, req1_rob;
  logic [PW-1:0] req0_payload, req1_payload;
  logic          req0_ready, req1_ready, md_valid, md_src;
  logic [PW-1:0] md_payload;
  logic [15:0]   conflict_cnt;

  logic          s_req0_ready, s_req1_ready, s_md_valid, s_md_src;
  logic [PW-1:0] s_md_payload;
  logic [3:0]    s_conflict_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_issue_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush), .rob_head(rob_head),
    .req0_valid(req0_valid), .req0_rob(req0_rob), .req0_payload(req0_payload), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rob(req1_rob), .req1_payload(req1_payload), .req1_ready(req1_ready),
    .md_allowin(md_allowin), .md_valid(md_valid), .md_payload(md_payload), .md_src(md_src),
    .conflict_cnt(conflict_cnt)
  );

  mul_div_issue_arbiter #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .flush(flush), .rob_head(rob_head),
    .req0_valid(req0_valid), .req0_rob(req0_rob), .req0_payload(req0_payload), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_rob(req1_rob), .req1_payload(req1_payload), .req1_ready(s_req1_ready),
    .md_allowin(md_allowin), .md_valid(s_md_valid), .md_payload(s_md_payload), .md_src(s_md_src),
    .conflict_cnt(s_conflict_cnt)
  );

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v0, input logic [RW-1:0] r0, input logic [PW-1:0] p0,
                         input logic v1, input logic [RW-1:0] r1, input logic [PW-1:0] p1);
    req0_valid = v0; req0_rob = r0; req0_payload = p0;
    req1_valid = v1; req1_rob = r1; req1_payload = p1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; md_allowin = 1'b1; rob_head = '0;
    set_req(1'b1, 4'd3, P0, 1'b0, 4'd0, '0);
    tick();
    @(negedge clk);
    chk("reset_ready0", req0_ready, 1'b0);
    tick();
    reset = 1'b0;
    set_req(1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
    chk("reset_md_valid", md_valid, 1'b0);
    chk("reset_md_payload", md_payload, '0);
    chk("reset_md_src", md_src, 1'b0);
    chk("reset_cnt", conflict_cnt, 16'd0);

    // Single request
    rob_head = 4'd0;
    set_req(1'b1, 4'd3, P0, 1'b0, 4'd0, '0);
    @(negedge clk);
    chk("t1_ready0", req0_ready, 1'b1);
    chk("t1_ready1", req1_ready, 1'b0);
    tick();
    set_req(1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
    chk("t1_md_valid", md_valid, 1'b1);
    chk("t1_md_src", md_src, 1'b0);
    chk("t1_md_payload", md_payload, P0);

    // Age priority
    rob_head = 4'd4;
    set_req(1'b1, 4'd9, P1, 1'b1, 4'd5, P2);
    @(negedge clk);
    chk("t2_ready1", req1_ready, 1'b1);
    chk("t2_ready0", req0_ready, 1'b0);
    tick();
    chk("t2_md_src", md_src, 1'b1);
    chk("t2_md_payload", md_payload, P2);
    chk("t2_cnt", conflict_cnt, 16'd1);
    req1_valid = 1'b0;
    @(negedge clk);
    chk("t2b_ready0", req0_ready, 1'b1);
    tick();
    chk("t2b_md_src", md_src, 1'b0);
    chk("t2b_md_payload", md_payload, P1);
    chk("t2b_cnt", conflict_cnt, 16'd1);

    // Wrap-around: head=14, rob 1 has age 3, rob 15 has age 1
    rob_head = 4'd14;
    set_req(1'b1, 4'd1, P1, 1'b1, 4'd15, P2);
    @(negedge clk);
    chk("t3_ready1", req1_ready, 1'b1);
    chk("t3_ready0", req0_ready, 1'b0);
    tick();
    chk("t3_md_src", md_src, 1'b1);
    chk("t3_cnt", conflict_cnt, 16'd2);

    // Backpressure with the P2 op held
    rob_head = 4'd0;
    md_allowin = 1'b0;
    set_req(1'b1, 4'd2, P3, 1'b1, 4'd3, P4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_ready0", i), req0_ready, 1'b0);
      chk($sformatf("t4_stall%0d_ready1", i), req1_ready, 1'b0);
      chk($sformatf("t4_stall%0d_payload", i), md_payload, P2);
      tick();
    end
    chk("t4_cnt_stall", conflict_cnt, 16'd7);
    md_allowin = 1'b1;
    @(negedge clk);
    chk("t4_release_ready0", req0_ready, 1'b1);
    chk("t4_release_ready1", req1_ready, 1'b0);
    tick();
    chk("t4_md_payload", md_payload, P3);
    chk("t4_md_src", md_src, 1'b0);
    chk("t4_cnt", conflict_cnt, 16'd8);

    // Flush while stalled on P3
    md_allowin = 1'b0;
    flush = 1'b1;
    set_req(1'b1, 4'd4, P5, 1'b1, 4'd8, P6);
    @(negedge clk);
    chk("t5_flush_ready0", req0_ready, 1'b0);
    chk("t5_flush_ready1", req1_ready, 1'b0);
    tick();
    flush = 1'b0;
    req1_valid = 1'b0;
    chk("t5_md_valid_flushed", md_valid, 1'b0);
    chk("t5_cnt_flush", conflict_cnt, 16'd8);
    @(negedge clk);
    chk("t5_after_ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    chk("t5_md_valid", md_valid, 1'b1);
    chk("t5_md_payload", md_payload, P5);

    // Saturation on the 4-bit counter instance
    md_allowin = 1'b1;
    set_req(1'b1, 4'd1, P1, 1'b1, 4'd2, P2);
    for (int i = 0; i < 20; i++) tick();
    chk("t6_sat_cnt", s_conflict_cnt, 4'd15);
    chk("t6_wide_cnt", conflict_cnt, 16'd28);
    set_req(1'b0, 4'd0, '0, 1'b0, 4'd0, '0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_reset_sat_cnt", s_conflict_cnt, 4'd0);
    chk("t6_reset_cnt", conflict_cnt, 16'd0);
    chk("t6_reset_md_valid", md_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
